// File: rtl/mem_wb_elastic.sv
// MEM->WB elastic stage: DEPTH-entry in-order buffer with valid/ready on both sides,
// synchronous flush/interrupt kill, and capture of the oldest in-flight PC on interrupt.
module mem_wb_elastic #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_alu,
  input  logic [DATA_W-1:0]          in_mem,
  input  logic [ADDR_W-1:0]          in_waddr,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       flush,
  input  logic                       interrupt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_alu,
  output logic [DATA_W-1:0]          out_mem,
  output logic [ADDR_W-1:0]          out_waddr,
  output logic [PC_W-1:0]            out_pc,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [PC_W-1:0]            intr_pc,
  output logic                       intr_pc_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] alu_q   [DEPTH];
  logic [DATA_W-1:0] mem_q   [DEPTH];
  logic [ADDR_W-1:0] waddr_q [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             head_valid;
  logic             push;
  logic             pop;
  logic             kill;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid = (cnt != '0);
  assign in_ready   = (cnt < CNT_W'(DEPTH));
  assign push       = in_valid & in_ready;
  assign pop        = head_valid & out_ready;
  assign kill       = flush | interrupt;

  // Control state: pointers, occupancy and interrupt PC capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      intr_pc       <= '0;
      intr_pc_valid <= 1'b0;
    end else begin
      intr_pc_valid <= 1'b0;
      if (kill) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        if (interrupt && head_valid) begin
          intr_pc       <= pc_q[rd_ptr];
          intr_pc_valid <= 1'b1;
        end else if (interrupt && in_valid) begin
          intr_pc       <= in_pc;
          intr_pc_valid <= 1'b1;
        end
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      cnt <= cnt + CNT_W'(1);
        else if (pop && !push) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Payload storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push && !kill) begin
      alu_q[wr_ptr]   <= in_alu;
      mem_q[wr_ptr]   <= in_mem;
      waddr_q[wr_ptr] <= in_waddr;
      pc_q[wr_ptr]    <= in_pc;
      ctrl_q[wr_ptr]  <= in_ctrl;
    end
  end

  // Empty buffer presents all-zero fields so no RegWrite leaks into WB.
  assign out_valid = head_valid;
  assign out_alu   = head_valid ? alu_q[rd_ptr]   : '0;
  assign out_mem   = head_valid ? mem_q[rd_ptr]   : '0;
  assign out_waddr = head_valid ? waddr_q[rd_ptr] : '0;
  assign out_pc    = head_valid ? pc_q[rd_ptr]    : '0;
  assign out_ctrl  = head_valid ? ctrl_q[rd_ptr]  : '0;
  assign count     = cnt;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Directed bench for mem_wb_elastic: vector table on a DEPTH=2 instance, hand sequences
// for async reset, and a queue-model stream on DEPTH=2 and DEPTH=3 instances.
module tb_mem_wb_elastic;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, flush, interrupt, out_valid, out_ready, intr_pc_valid;
  logic [31:0] in_alu, in_mem, in_pc, out_alu, out_mem, out_pc, intr_pc;
  logic [4:0]  in_waddr, out_waddr;
  logic [1:0]  in_ctrl, out_ctrl, count;

  logic        t3_in_valid, t3_in_ready, t3_out_valid, t3_out_ready, t3_ipv;
  logic [31:0] t3_in_pc, t3_out_alu, t3_out_mem, t3_out_pc, t3_ipc;
  logic [4:0]  t3_out_waddr;
  logic [1:0]  t3_out_ctrl, t3_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_elastic #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_mem(in_mem), .in_waddr(in_waddr), .in_pc(in_pc),
    .in_ctrl(in_ctrl), .flush(flush), .interrupt(interrupt), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu(out_alu), .out_mem(out_mem), .out_waddr(out_waddr),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .count(count), .intr_pc(intr_pc),
    .intr_pc_valid(intr_pc_valid)
  );

  mem_wb_elastic #(.DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(t3_in_valid), .in_ready(t3_in_ready),
    .in_alu(t3_in_pc), .in_mem(t3_in_pc), .in_waddr(5'd1), .in_pc(t3_in_pc),
    .in_ctrl(2'b01), .flush(1'b0), .interrupt(1'b0), .out_valid(t3_out_valid),
    .out_ready(t3_out_ready), .out_alu(t3_out_alu), .out_mem(t3_out_mem),
    .out_waddr(t3_out_waddr), .out_pc(t3_out_pc), .out_ctrl(t3_out_ctrl),
    .count(t3_count), .intr_pc(t3_ipc), .intr_pc_valid(t3_ipv)
  );

  typedef struct {
    logic        iv;
    logic [31:0] alu, mem;
    logic [4:0]  wa;
    logic [31:0] pc;
    logic [1:0]  ctrl;
    logic        ordy, fl, it;
    logic        e_ov;
    logic [31:0] e_alu, e_mem;
    logic [4:0]  e_wa;
    logic [31:0] e_pc;
    logic [1:0]  e_ctrl, e_cnt;
    logic        e_ir, e_ipv;
    logic [31:0] e_ipc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] wa, input logic [31:0] pc, input logic [1:0] ctrl,
                       input logic ordy, input logic fl, input logic it);
    in_valid = iv; in_alu = alu; in_mem = mem; in_waddr = wa; in_pc = pc;
    in_ctrl = ctrl; out_ready = ordy; flush = fl; interrupt = it;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_pc"},    out_pc, 32'd0);
    chk({tag, " out_ctrl"},  32'(out_ctrl), 32'd0);
    chk({tag, " count"},     32'(count), 32'd0);
    chk({tag, " in_ready"},  32'(in_ready), 32'd1);
  endtask

  // Push one instruction into an empty buffer, see it next cycle, then see it leave.
  task automatic single_push(input string tag);
    @(negedge clk);
    drive(1, 32'h1111, 32'h2222, 5'd3, 32'h40, 2'b01, 1, 0, 0);
    @(posedge clk); #1;
    chk({tag, " head valid"}, 32'(out_valid), 32'd1);
    chk({tag, " head alu"},   out_alu, 32'h1111);
    chk({tag, " head mem"},   out_mem, 32'h2222);
    chk({tag, " head waddr"}, 32'(out_waddr), 32'd3);
    chk({tag, " head pc"},    out_pc, 32'h40);
    chk({tag, " head ctrl"},  32'(out_ctrl), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk_empty({tag, " drained"});
  endtask

  logic [31:0] q2[$];
  logic [31:0] q3[$];

  initial begin
    vecs = '{
      '{1,'h1111,'h2222,3,'h40,2'b01,1,0,0,   1,'h1111,'h2222,3,'h40,2'b01,1,1,0,0},
      '{0,0,0,0,0,0,1,0,0,                    0,0,0,0,0,0,0,1,0,0},
      '{1,'hA0,'hB0,1,'h40,2'b11,0,0,0,       1,'hA0,'hB0,1,'h40,2'b11,1,1,0,0},
      '{1,'hA4,'hB4,2,'h44,2'b10,0,0,0,       1,'hA0,'hB0,1,'h40,2'b11,2,0,0,0},
      '{1,'hA8,'hB8,6,'h48,2'b01,0,0,0,       1,'hA0,'hB0,1,'h40,2'b11,2,0,0,0},
      '{1,'hA8,'hB8,6,'h48,2'b01,1,0,0,       1,'hA4,'hB4,2,'h44,2'b10,1,1,0,0},
      '{1,'hA8,'hB8,6,'h48,2'b01,1,0,0,       1,'hA8,'hB8,6,'h48,2'b01,1,1,0,0},
      '{0,0,0,0,0,0,1,0,0,                    0,0,0,0,0,0,0,1,0,0},
      '{1,'hC1,'hD1,4,'h80,2'b01,0,0,0,       1,'hC1,'hD1,4,'h80,2'b01,1,1,0,0},
      '{1,'hC2,'hD2,5,'h84,2'b01,0,0,0,       1,'hC1,'hD1,4,'h80,2'b01,2,0,0,0},
      '{1,'hC3,'hD3,6,'h88,2'b01,0,0,1,       0,0,0,0,0,0,0,1,1,'h80},
      '{0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,0,0,1,0,'h80},
      '{1,'hE1,'hF1,8,'h100,2'b01,0,1,1,      0,0,0,0,0,0,0,1,1,'h100},
      '{0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,0,0,1,0,'h100},
      '{1,'hD0,'hE0,7,'h200,2'b11,0,0,0,      1,'hD0,'hE0,7,'h200,2'b11,1,1,0,'h100},
      '{1,'hD4,'hE4,7,'h204,2'b11,1,1,0,      0,0,0,0,0,0,0,1,0,'h100},
      '{0,0,0,0,0,0,0,0,1,                    0,0,0,0,0,0,0,1,0,'h100}
    };

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    t3_in_valid = 0; t3_in_pc = 0; t3_out_ready = 0;
    repeat (2) @(negedge clk);
    chk_empty("reset");
    chk("reset intr_pc", intr_pc, 32'd0);
    chk("reset intr_pc_valid", 32'(intr_pc_valid), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].alu, vecs[i].mem, vecs[i].wa, vecs[i].pc, vecs[i].ctrl,
            vecs[i].ordy, vecs[i].fl, vecs[i].it);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d out_alu", i), out_alu, vecs[i].e_alu);
      chk($sformatf("v%0d out_mem", i), out_mem, vecs[i].e_mem);
      chk($sformatf("v%0d out_waddr", i), 32'(out_waddr), 32'(vecs[i].e_wa));
      chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].e_pc);
      chk($sformatf("v%0d out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].e_ctrl));
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d intr_pc_valid", i), 32'(intr_pc_valid), 32'(vecs[i].e_ipv));
      chk($sformatf("v%0d intr_pc", i), intr_pc, vecs[i].e_ipc);
    end

    // Async reset between edges with two entries queued.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1, 32'h300 + 32'(k), 32'h0, 5'd9, 32'h300 + 32'(4 * k), 2'b01, 0, 0, 0);
      @(posedge clk);
    end
    #1 chk("pre-reset count", 32'(count), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 chk_empty("async reset");
    @(negedge clk) reset = 1'b0;
    single_push("post-reset");

    // Reset must kill a pending intr_pc_valid pulse.
    @(negedge clk);
    drive(1, 32'h5, 32'h6, 5'd2, 32'h500, 2'b01, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("intr pulse before reset", 32'(intr_pc_valid), 32'd1);
    chk("intr pc before reset", intr_pc, 32'h500);
    interrupt = 1'b0;
    #2 reset = 1'b1;
    #1 chk("intr pulse after reset", 32'(intr_pc_valid), 32'd0);
    chk("intr pc after reset", intr_pc, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Streaming against a queue model on both depths.
    begin
      logic [31:0] n2, n3;
      logic iv, ordy, p2, o2, p3, o3;
      n2 = 32'h1000; n3 = 32'h2000;
      for (int c = 0; c < 44; c++) begin
        @(negedge clk);
        chk($sformatf("s%0d d2 count", c), 32'(count), 32'(q2.size()));
        chk($sformatf("s%0d d2 in_ready", c), 32'(in_ready), 32'(q2.size() < 2));
        if (q2.size() > 0) chk($sformatf("s%0d d2 head pc", c), out_pc, q2[0]);
        else chk($sformatf("s%0d d2 out_valid", c), 32'(out_valid), 32'd0);
        chk($sformatf("s%0d d3 count", c), 32'(t3_count), 32'(q3.size()));
        chk($sformatf("s%0d d3 in_ready", c), 32'(t3_in_ready), 32'(q3.size() < 3));
        if (q3.size() > 0) chk($sformatf("s%0d d3 head pc", c), t3_out_pc, q3[0]);
        else chk($sformatf("s%0d d3 out_valid", c), 32'(t3_out_valid), 32'd0);
        iv   = (c < 20) ? 1'b1 : (c < 36) ? (c % 3 != 0) : 1'b0;
        ordy = (c < 4) ? 1'b0 : (c < 20) ? 1'b1 : (c >= 36) ? 1'b1 : c[0];
        drive(iv, n2, ~n2, 5'd1, n2, 2'b01, ordy, 0, 0);
        t3_in_valid = iv; t3_in_pc = n3; t3_out_ready = ordy;
        p2 = iv && (q2.size() < 2); o2 = ordy && (q2.size() > 0);
        p3 = iv && (q3.size() < 3); o3 = ordy && (q3.size() > 0);
        @(posedge clk);
        if (o2) void'(q2.pop_front());
        if (p2) begin q2.push_back(n2); n2 = n2 + 32'd4; end
        if (o3) void'(q3.pop_front());
        if (p3) begin q3.push_back(n3); n3 = n3 + 32'd4; end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
